// File: rtl/but_writeback_q2_if.sv
// Issue-side and RAM-write-side signal bundle of the Q2 butterfly write-back unit.
// slave = write-back unit, master = controller / RAM / testbench side.
interface but_writeback_q2_if #(
    parameter int D  = 30,
    parameter int AW = 8
);
    logic          iFSM_START;
    logic [1:0]    iMODE;
    logic          iISSUE;
    logic [AW-1:0] iADDR_A;
    logic [AW-1:0] iADDR_B;
    logic          iLAST;
    logic [D-1:0]  iBUT_A;
    logic [D-1:0]  iBUT_B;
    logic          oISSUE_RDY;
    logic          oWE_A;
    logic [AW-1:0] oWADDR_A;
    logic [D-1:0]  oWDATA_A;
    logic          oWE_B;
    logic [AW-1:0] oWADDR_B;
    logic [D-1:0]  oWDATA_B;
    logic          iWRDY;
    logic          oBUSY;
    logic          oDONE;
    logic [AW:0]   oCNT;
    logic [1:0]    oERR;

    modport slave (
        input  iFSM_START, iMODE, iISSUE, iADDR_A, iADDR_B, iLAST, iBUT_A, iBUT_B, iWRDY,
        output oISSUE_RDY, oWE_A, oWADDR_A, oWDATA_A, oWE_B, oWADDR_B, oWDATA_B,
               oBUSY, oDONE, oCNT, oERR
    );

    modport master (
        output iFSM_START, iMODE, iISSUE, iADDR_A, iADDR_B, iLAST, iBUT_A, iBUT_B, iWRDY,
        input  oISSUE_RDY, oWE_A, oWADDR_A, oWDATA_A, oWE_B, oWADDR_B, oWDATA_B,
               oBUSY, oDONE, oCNT, oERR
    );
endinterface

// File: rtl/but_writeback_q2.sv
// Q2 butterfly write-back: delays issue addresses by LAT, pairs them with oA/oB, FIFOs them to the RAM.
// Latency: first write presented LAT+1 cycles after issue; 1 butterfly/cycle sustained.
// Backpressure: iWRDY stalls the FIFO head; oISSUE_RDY credits issues against FIFO space. Option: WB_ADDR_BITREV_EN.
module but_writeback_q2 #(
    parameter int          D       = 30,
    parameter int unsigned PARAM_Q = 536903681,
    parameter int          AW      = 8,
    parameter int          LAT     = 3,
    parameter int          FDEPTH  = 8
) (
    input  logic                  iSYS_CLK,
    input  logic                  iSYS_RST,
    but_writeback_q2_if.slave     bus
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(LAT + 1);
    localparam int SW = PW + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [D-1:0]  dat_a;
        logic [D-1:0]  dat_b;
    } entry_t;

    state_t        r_state;
    logic [1:0]    r_mode;
    logic          r_busy;
    logic          r_done;
    logic [AW:0]   r_cnt;
    logic [1:0]    r_err;

    logic          r_dl_vld [LAT];
    logic [AW-1:0] r_dl_aa  [LAT];
    logic [AW-1:0] r_dl_ab  [LAT];
    logic [LW-1:0] r_dl_cnt;

    entry_t        r_mem [FDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_fcnt;

    logic          w_pwm;
    logic          w_rdy;
    logic          w_accept;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_nempty;
    logic          w_we_b;
    logic          w_rng_err;
    logic          w_drain_ok;
    logic [SW-1:0] w_used;
    entry_t        w_push_dat;
    entry_t        w_head;
    logic [AW-1:0] w_out_aa;
    logic [AW-1:0] w_out_ab;

    // Mode 3 is reserved and behaves as PWM, so bit 1 alone identifies PWM.
    assign w_pwm    = r_mode[1];

    // Credits cover entries still in the delay line, so a full FIFO can never be overrun.
    assign w_used   = SW'(r_fcnt) + SW'(r_dl_cnt);
    assign w_rdy    = (w_used < SW'(FDEPTH));
    assign w_accept = (r_state == S_RUN) && bus.iISSUE && w_rdy;
    assign w_drop   = (r_state == S_RUN) && bus.iISSUE && !w_rdy;

    assign w_push   = r_dl_vld[LAT-1];
    assign w_nempty = (r_fcnt != '0);
    assign w_pop    = w_nempty && bus.iWRDY;
    assign w_head   = r_mem[r_rptr];
    assign w_we_b   = w_nempty && !w_pwm;

    assign w_push_dat = '{addr_a: r_dl_aa[LAT-1],
                          addr_b: r_dl_ab[LAT-1],
                          dat_a:  bus.iBUT_A,
                          dat_b:  bus.iBUT_B};

    assign w_rng_err = w_push && ((bus.iBUT_A >= D'(PARAM_Q)) ||
                                  (!w_pwm && (bus.iBUT_B >= D'(PARAM_Q))));

    // Stage completes on the cycle the last buffered write is accepted.
    assign w_drain_ok = (r_dl_cnt == '0) &&
                        ((r_fcnt == '0) || ((r_fcnt == CW'(1)) && w_pop));

`ifdef WB_ADDR_BITREV_EN
    function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    assign w_out_aa = f_bitrev(w_head.addr_a);
    assign w_out_ab = f_bitrev(w_head.addr_b);
`else
    assign w_out_aa = w_head.addr_a;
    assign w_out_ab = w_head.addr_b;
`endif

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            for (int i = 0; i < LAT; i++) begin
                r_dl_vld[i] <= 1'b0;
                r_dl_aa[i]  <= '0;
                r_dl_ab[i]  <= '0;
            end
            r_dl_cnt <= '0;
        end else begin
            r_dl_vld[0] <= w_accept;
            r_dl_aa[0]  <= bus.iADDR_A;
            r_dl_ab[0]  <= bus.iADDR_B;
            for (int i = 1; i < LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_aa[i]  <= r_dl_aa[i-1];
                r_dl_ab[i]  <= r_dl_ab[i-1];
            end
            case ({w_accept, w_push})
                2'b10:   r_dl_cnt <= r_dl_cnt + LW'(1);
                2'b01:   r_dl_cnt <= r_dl_cnt - LW'(1);
                default: r_dl_cnt <= r_dl_cnt;
            endcase
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_dat;
        end
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CW'(1);
                2'b01:   r_fcnt <= r_fcnt - CW'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
        if (!iSYS_RST) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 2'b00;
        end else begin
            r_done <= 1'b0;
            if (w_pop && (r_cnt != {1'b1, {AW{1'b0}}})) begin
                r_cnt <= r_cnt + (AW+1)'(1);
            end
            if (w_rng_err) begin
                r_err[0] <= 1'b1;
            end
            if (w_drop) begin
                r_err[1] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.iFSM_START) begin
                        r_state <= S_RUN;
                        r_mode  <= bus.iMODE;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_err   <= 2'b00;
                    end
                end
                S_RUN: begin
                    if (w_accept && bus.iLAST) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_ok) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oISSUE_RDY = w_rdy;
    assign bus.oWE_A      = w_nempty;
    assign bus.oWADDR_A   = w_nempty ? w_out_aa : '0;
    assign bus.oWDATA_A   = w_nempty ? w_head.dat_a : '0;
    assign bus.oWE_B      = w_we_b;
    assign bus.oWADDR_B   = w_we_b ? w_out_ab : '0;
    assign bus.oWDATA_B   = w_we_b ? w_head.dat_b : '0;
    assign bus.oBUSY      = r_busy;
    assign bus.oDONE      = r_done;
    assign bus.oCNT       = r_cnt;
    assign bus.oERR       = r_err;

endmodule

// File: tb/tb_but_writeback_q2.sv
// Directed bench for but_writeback_q2: scoreboard of expected RAM writes checked at each accepted write.
// Butterfly results are scheduled LAT cycles after each issue from a per-cycle data table.
module tb_but_writeback_q2;
    localparam int D      = 30;
    localparam int AW     = 8;
    localparam int LAT    = 3;
    localparam int FDEPTH = 8;
    localparam logic [D-1:0] QV = 30'd536903681;

    typedef struct packed {
        logic          we_b;
        logic [AW-1:0] aa;
        logic [AW-1:0] ab;
        logic [D-1:0]  da;
        logic [D-1:0]  db;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    but_writeback_q2_if #(.D(D), .AW(AW)) bus();

    but_writeback_q2 #(.D(D), .PARAM_Q(536903681), .AW(AW), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
        .iSYS_CLK (clk),
        .iSYS_RST (rst_n),
        .bus      (bus)
    );

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           first_wr_cyc = -1;
    int           last_wr_cyc = -1;
    int           wr_cnt = 0;
    int           done_cnt = 0;
    logic [D-1:0] tab_a [256];
    logic [D-1:0] tab_b [256];

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef WB_ADDR_BITREV_EN
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m);
        bus.iFSM_START = 1'b1;
        bus.iMODE      = m;
        tick();
        bus.iFSM_START = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic last,
                         input logic [D-1:0] da, input logic [D-1:0] db,
                         input logic pwm, input logic acc);
        exp_t e;
        bus.iISSUE  = 1'b1;
        bus.iADDR_A = a;
        bus.iADDR_B = b;
        bus.iLAST   = last;
        if (acc) begin
            tab_a[(cyc + LAT) % 256] = da;
            tab_b[(cyc + LAT) % 256] = db;
            e.we_b = !pwm;
            e.aa   = exp_addr(a);
            e.ab   = pwm ? '0 : exp_addr(b);
            e.da   = da;
            e.db   = pwm ? '0 : db;
            sb.push_back(e);
        end
        tick();
        bus.iISSUE = 1'b0;
        bus.iLAST  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.oDONE === 1'b1) begin
                dcyc = cyc;
                break;
            end
        end
        checks++;
        assert (dcyc >= 0) else begin
            errors++;
            $error("FAIL done_timeout observed=none expected=oDONE within %0d cycles", budget);
        end
    endtask

    function automatic logic [D-1:0] rnd_res();
        return D'($urandom_range(0, 536903680));
    endfunction

    // Butterfly result driver: value for cycle k is whatever the bench scheduled at tab[k].
    initial begin
        for (int i = 0; i < 256; i++) begin
            tab_a[i] = '0;
            tab_b[i] = '0;
        end
        bus.iBUT_A = '0;
        bus.iBUT_B = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.iBUT_A = tab_a[cyc % 256];
            bus.iBUT_B = tab_b[cyc % 256];
            tab_a[cyc % 256] = '0;
            tab_b[cyc % 256] = '0;
        end
    end

    // Write monitor: scoreboard compare on accepted writes, stability check while stalled.
    initial begin
        exp_t e;
        exp_t o;
        logic [2*AW+2*D-1:0] snap;
        logic stall_v;
        stall_v = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (bus.oDONE === 1'b1) done_cnt++;
            if (bus.oWE_A === 1'b1) begin
                if (stall_v) begin
                    checks++;
                    assert ({bus.oWADDR_A, bus.oWADDR_B, bus.oWDATA_A, bus.oWDATA_B} === snap) else begin
                        errors++;
                        $error("FAIL stall_hold observed=%0h expected=%0h",
                               {bus.oWADDR_A, bus.oWADDR_B, bus.oWDATA_A, bus.oWDATA_B}, snap);
                    end
                end
                if (bus.iWRDY === 1'b1) begin
                    checks++;
                    assert (sb.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_write observed addr=%0h expected no write", bus.oWADDR_A);
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        o.we_b = bus.oWE_B;
                        o.aa   = bus.oWADDR_A;
                        o.ab   = e.we_b ? bus.oWADDR_B : {AW{1'b0}};
                        o.da   = bus.oWDATA_A;
                        o.db   = bus.oWDATA_B;
                        checks++;
                        assert (o === e) else begin
                            errors++;
                            $error("FAIL write observed=%0h expected=%0h", o, e);
                        end
                    end
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    last_wr_cyc = cyc;
                    wr_cnt++;
                    stall_v = 1'b0;
                end else begin
                    stall_v = 1'b1;
                    snap = {bus.oWADDR_A, bus.oWADDR_B, bus.oWDATA_A, bus.oWDATA_B};
                end
            end else begin
                stall_v = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int dc;
        int wc;
        int dn;
        logic got;
        bus.iFSM_START = 1'b0;
        bus.iMODE      = 2'd0;
        bus.iISSUE     = 1'b0;
        bus.iADDR_A    = '0;
        bus.iADDR_B    = '0;
        bus.iLAST      = 1'b0;
        bus.iWRDY      = 1'b0;
        rst_n          = 1'b0;
        #3;
        chk("rst_we_a",   bus.oWE_A, 0);
        chk("rst_we_b",   bus.oWE_B, 0);
        chk("rst_rdy",    bus.oISSUE_RDY, 1);
        chk("rst_busy",   bus.oBUSY, 0);
        chk("rst_done",   bus.oDONE, 0);
        chk("rst_cnt",    bus.oCNT, 0);
        chk("rst_err",    bus.oERR, 0);
        chk("rst_waddr",  {bus.oWADDR_A, bus.oWADDR_B}, 0);
        chk("rst_wdata",  {bus.oWDATA_A, bus.oWDATA_B}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // CT stage, four back-to-back issues
        bus.iWRDY = 1'b1;
        start(2'd0);
        chk("ct_busy", bus.oBUSY, 1);
        n0 = cyc;
        wc = wr_cnt;
        for (int k = 0; k < 4; k++) begin
            issue(AW'(k), AW'(128 + k), (k == 3), rnd_res(), rnd_res(), 1'b0, 1'b1);
        end
        wait_done(60, dc);
        chk("ct_first_lat", first_wr_cyc, n0 + LAT + 1);
        chk("ct_done_after_last", dc, last_wr_cyc + 1);
        chk("ct_cnt", bus.oCNT, 4);
        chk("ct_writes", wr_cnt - wc, 4);
        chk("ct_err", bus.oERR, 0);
        chk("ct_busy_done", bus.oBUSY, 0);
        tick();
        chk("ct_idle_done", bus.oDONE, 0);

        // PWM stage: only A written
        start(2'd2);
        issue(AW'(5), AW'(77), 1'b1, 30'h1234567, rnd_res(), 1'b1, 1'b1);
        wait_done(60, dc);
        chk("pwm_cnt", bus.oCNT, 1);
        chk("pwm_err", bus.oERR, 0);
        tick();

        // Single CT issue at (1,3): exercises address mapping
        start(2'd0);
        issue(AW'(1), AW'(3), 1'b1, rnd_res(), rnd_res(), 1'b0, 1'b1);
        wait_done(60, dc);
        chk("addr_cnt", bus.oCNT, 1);
        chk("addr_sb_empty", sb.size(), 0);
        tick();

        // Backpressure: RAM stalled, credits run out after FDEPTH issues
        bus.iWRDY = 1'b0;
        start(2'd0);
        wc = wr_cnt;
        for (int k = 0; k < FDEPTH; k++) begin
            chk("bp_rdy_open", bus.oISSUE_RDY, 1);
            issue(AW'(16 + k), AW'(48 + k), 1'b0, rnd_res(), rnd_res(), 1'b0, 1'b1);
        end
        chk("bp_rdy_closed", bus.oISSUE_RDY, 0);
        repeat (6) tick();
        chk("bp_rdy_still_closed", bus.oISSUE_RDY, 0);
        chk("bp_no_writes", wr_cnt - wc, 0);
        chk("bp_err_clean", bus.oERR, 0);
        issue(AW'(99), AW'(99), 1'b0, '0, '0, 1'b0, 1'b0);
        chk("drop_err", bus.oERR, 2'b10);
        bus.iWRDY = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.oISSUE_RDY === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_rdy_reopen", got, 1);
        issue(AW'(40), AW'(41), 1'b1, rnd_res(), QV, 1'b0, 1'b1);
        wait_done(80, dc);
        chk("range_err", bus.oERR, 2'b11);
        chk("bp_cnt", bus.oCNT, FDEPTH + 1);
        chk("bp_writes", wr_cnt - wc, FDEPTH + 1);
        tick();

        // Reset while draining with three buffered results
        bus.iWRDY = 1'b0;
        start(2'd0);
        for (int k = 0; k < 3; k++) begin
            issue(AW'(200 + k), AW'(210 + k), (k == 2), rnd_res(), rnd_res(), 1'b0, 1'b1);
        end
        repeat (LAT + 2) tick();
        chk("mid_busy", bus.oBUSY, 1);
        chk("mid_we_a", bus.oWE_A, 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mrst_we", {bus.oWE_A, bus.oWE_B}, 0);
        chk("mrst_rdy", bus.oISSUE_RDY, 1);
        chk("mrst_busy_done", {bus.oBUSY, bus.oDONE}, 0);
        chk("mrst_cnt_err", {bus.oCNT, bus.oERR}, 0);
        chk("mrst_bus", {bus.oWADDR_A, bus.oWADDR_B, bus.oWDATA_A, bus.oWDATA_B}, 0);
        dn = done_cnt;
        wc = wr_cnt;
        bus.iWRDY = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("mrst_no_done", done_cnt - dn, 0);
        chk("mrst_no_writes", wr_cnt - wc, 0);
        start(2'd0);
        issue(AW'(7), AW'(135), 1'b0, rnd_res(), rnd_res(), 1'b0, 1'b1);
        issue(AW'(8), AW'(136), 1'b1, rnd_res(), rnd_res(), 1'b0, 1'b1);
        wait_done(60, dc);
        chk("post_cnt", bus.oCNT, 2);
        chk("post_err", bus.oERR, 0);
        chk("post_writes", wr_cnt - wc, 2);
        tick();
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
